// File: rtl/alu_pkg.sv
// Shared types for the ALU scheduler: instruction format, operand views and FSM states.
// Also holds the enum-range and divide-by-zero helpers used by the datapath and scheduler.
package alu_pkg;

  typedef enum logic [2:0] {add, sub, mul, div, sl, sr} opcode_t;

  // Two bits wide so that a corrupted or unsupported operand type can be told apart.
  typedef enum logic [1:0] {sign, unsign} operand_type_t;

  typedef union packed {
    logic [31:0]      u_data;
    bit signed [31:0] s_data;
  } data_t;

  typedef struct packed {
    opcode_t       opc;
    operand_type_t op_type;
    data_t         op_a;
    data_t         op_b;
  } instr_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;

  localparam logic [31:0] DZ_RESULT_DEFAULT = 32'h0000_0000;

  function automatic logic is_legal(input instr_t instr);
    return (instr.opc inside {add, sub, mul, div, sl, sr}) &&
           (instr.op_type inside {sign, unsign});
  endfunction

  function automatic logic is_div_zero(input instr_t instr);
    return is_legal(instr) && (instr.opc == div) && (instr.op_b.u_data == 32'h0);
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Handshake bundle between the instruction issuers, the scheduler and the result consumer.
// The master side drives requests and rsp_ready; the slave side is the scheduler.
interface alu_sched_if;
  import alu_pkg::*;

  logic   req0_valid;
  logic   req0_ready;
  instr_t req0_instr;
  logic   req1_valid;
  logic   req1_ready;
  instr_t req1_instr;
  logic   rsp_valid;
  logic   rsp_ready;
  data_t  rsp_data;
  logic   rsp_id;
  logic   rsp_dz;
  logic   busy;

  modport master (
    output req0_valid, req0_instr, req1_valid, req1_instr, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_dz, busy
  );

  modport slave (
    input  req0_valid, req0_instr, req1_valid, req1_instr, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_dz, busy
  );

endinterface

// File: rtl/alu.sv
// Shared 32-bit combinational ALU datapath. Illegal opcode/operand type yields zero;
// divide by zero yields zero here and is overridden by the scheduler.
module alu
  import alu_pkg::*;
(
  input  instr_t instr,
  output data_t  result
);

  data_t a;
  data_t b;

  assign a = instr.op_a;
  assign b = instr.op_b;

  always_comb begin
    result = '0;
    if (is_legal(instr)) begin
      if (instr.op_type == sign) begin
        case (instr.opc)
          add: result.s_data = a.s_data + b.s_data;
          sub: result.s_data = a.s_data - b.s_data;
          mul: result.s_data = a.s_data * b.s_data;
          div: begin
            // The overflow quotient is pinned explicitly so no simulator or tool has to guess.
            if (b.u_data == 32'h0)
              result.u_data = 32'h0;
            else if (a.u_data == 32'h8000_0000 && b.u_data == 32'hFFFF_FFFF)
              result.u_data = 32'h8000_0000;
            else
              result.s_data = a.s_data / b.s_data;
          end
          sl:      result.s_data = a.s_data <<< 1;
          sr:      result.s_data = a.s_data >>> 1;
          default: result = '0;
        endcase
      end else begin
        case (instr.opc)
          add: result.u_data = a.u_data + b.u_data;
          sub: result.u_data = a.u_data - b.u_data;
          mul: result.u_data = a.u_data * b.u_data;
          div: result.u_data = (b.u_data == 32'h0) ? 32'h0 : a.u_data / b.u_data;
          sl:      result.u_data = a.u_data << 2;
          sr:      result.u_data = a.u_data >> 2;
          default: result = '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter. prio names the requester that wins a tie and
// moves to the loser on every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic prio;

  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      prio <= 1'b0;
    else if (en && |req)
      prio <= gnt[0];
  end

endmodule

// File: rtl/alu_sched.sv
// Scheduler for the shared ALU: round-robin accepts one instruction at a time,
// executes it for one cycle and holds the tagged result until the consumer takes it.
module alu_sched
  import alu_pkg::*;
#(
  parameter logic [31:0] DZ_RESULT = DZ_RESULT_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  alu_sched_if.slave bus
);

  sched_state_t state;
  instr_t       instr_q;
  logic         id_q;
  logic [1:0]   gnt;
  logic         arb_en;
  data_t        alu_result;

  // Grants only while idle; held off during reset so ready reads low in the reset cycle.
  assign arb_en = (state == IDLE) && !rst;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.req1_valid, bus.req0_valid}),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.busy       = (state != IDLE);

  alu u_alu (
    .instr  (instr_q),
    .result (alu_result)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: instr_q/id_q are not reset; they are always written before EXEC reads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            instr_q <= gnt[1] ? bus.req1_instr : bus.req0_instr;
            id_q    <= gnt[1];
            state   <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_data.u_data <= is_div_zero(instr_q) ? DZ_RESULT : alu_result.u_data;
          bus.rsp_dz          <= is_div_zero(instr_q);
          bus.rsp_id          <= id_q;
          bus.rsp_valid       <= 1'b1;
          state               <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: a scoreboard fed on every accept and drained on
// every response handshake, plus per-scenario timing and value checks.
module tb_alu_sched;
  import alu_pkg::*;

  localparam logic [31:0] DZ = 32'hDEAD_0BAD;

  typedef struct {
    logic [31:0] data;
    logic        id;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_sched_if bus ();

  alu_sched #(.DZ_RESULT(DZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic instr_t mk(input opcode_t o, input operand_type_t t,
                                input logic [31:0] a, input logic [31:0] b);
    instr_t i;
    i.opc         = o;
    i.op_type     = t;
    i.op_a.u_data = a;
    i.op_b.u_data = b;
    return i;
  endfunction

  // Reference model, written with 64-bit arithmetic and explicit bit manipulation.
  function automatic exp_t model(input instr_t i, input logic id);
    exp_t        e;
    logic [31:0] a;
    logic [31:0] b;
    longint      sa;
    longint      sbv;
    longint      r;
    a = i.op_a.u_data;
    b = i.op_b.u_data;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    e.id = id;
    e.dz = 1'b0;
    e.data = 32'h0;
    if (!(i.opc inside {add, sub, mul, div, sl, sr}) || !(i.op_type inside {sign, unsign}))
      return e;
    if (i.opc == div && b == 32'h0) begin
      e.data = DZ;
      e.dz = 1'b1;
      return e;
    end
    case (i.opc)
      add: e.data = a + b;
      sub: e.data = a - b;
      mul: begin
        r = (i.op_type == sign) ? sa * sbv : longint'({32'h0, a}) * longint'({32'h0, b});
        e.data = r[31:0];
      end
      div: begin
        r = (i.op_type == sign) ? sa / sbv : longint'({32'h0, a}) / longint'({32'h0, b});
        e.data = r[31:0];
      end
      sl: e.data = (i.op_type == sign) ? {a[30:0], 1'b0} : {a[29:0], 2'b00};
      sr: e.data = (i.op_type == sign) ? {a[31], a[31:1]} : {2'b00, a[31:2]};
      default: e.data = 32'h0;
    endcase
    return e;
  endfunction

  // Scoreboard: push on accept, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      checks++;
      if (bus.req0_ready && bus.req1_ready) begin
        failures++;
        $display("FAIL both_ready req0_ready=%b req1_ready=%b", bus.req0_ready, bus.req1_ready);
      end
      if (bus.req0_valid && bus.req0_ready) sb.push_back(model(bus.req0_instr, 1'b0));
      if (bus.req1_valid && bus.req1_ready) sb.push_back(model(bus.req1_instr, 1'b1));
      if (bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_rsp got data=%h id=%b dz=%b", bus.rsp_data.u_data,
                   bus.rsp_id, bus.rsp_dz);
        end else begin
          mon_e = sb.pop_front();
          if ({bus.rsp_data.u_data, bus.rsp_id, bus.rsp_dz} !== {mon_e.data, mon_e.id, mon_e.dz}) begin
            failures++;
            $display("FAIL sb_rsp got data=%h id=%b dz=%b expected data=%h id=%b dz=%b",
                     bus.rsp_data.u_data, bus.rsp_id, bus.rsp_dz, mon_e.data, mon_e.id, mon_e.dz);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic v, input instr_t ins);
    if (id) begin
      bus.req1_valid = v;
      bus.req1_instr = ins;
    end else begin
      bus.req0_valid = v;
      bus.req0_instr = ins;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d busy=%b expected pending=0 busy=0", name, sb.size(), bus.busy);
    end
  endtask

  // Issue one instruction alone, check handshake timing and the explicit expected result.
  task automatic run_one(input logic id, input instr_t ins, input logic [31:0] exp_data,
                         input logic exp_dz, input string name);
    int   n;
    logic rdy;
    tick();
    bus.rsp_ready = 1'b1;
    set_req(id, 1'b1, ins);
    n = 0;
    @(negedge clk);
    rdy = id ? bus.req1_ready : bus.req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = id ? bus.req1_ready : bus.req0_ready;
      n++;
    end
    checks++;
    if (!rdy) begin
      failures++;
      $display("FAIL %s_ready got ready=0 expected 1", name);
    end
    tick();
    set_req(id, 1'b0, ins);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_exec got rsp_valid=%b busy=%b expected 0/1", name, bus.rsp_valid, bus.busy);
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_data.u_data, bus.rsp_id, bus.rsp_dz} !== {1'b1, exp_data, id, exp_dz}) begin
      failures++;
      $display("FAIL %s_rsp got valid=%b data=%h id=%b dz=%b expected valid=1 data=%h id=%b dz=%b",
               name, bus.rsp_valid, bus.rsp_data.u_data, bus.rsp_id, bus.rsp_dz, exp_data, id, exp_dz);
    end
    wait_drain(name);
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_instr = mk(add, sign, 32'd1, 32'd2);
    bus.req1_instr = mk(add, sign, 32'd3, 32'd4);
    bus.rsp_ready  = 1'b1;
    rst = 1'b1;
    sb.delete();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_data.u_data, bus.rsp_id, bus.rsp_dz, bus.req0_ready,
         bus.req1_ready, bus.busy} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got valid=%b data=%h id=%b dz=%b r0=%b r1=%b busy=%b expected all 0",
               bus.rsp_valid, bus.rsp_data.u_data, bus.rsp_id, bus.rsp_dz, bus.req0_ready,
               bus.req1_ready, bus.busy);
    end
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_one(1'b0, mk(add, sign, 32'd5, 32'hFFFF_FFF9), 32'hFFFF_FFFE, 1'b0, "add_s");
    run_one(1'b1, mk(sub, unsign, 32'd3, 32'd5), 32'hFFFF_FFFE, 1'b0, "sub_u");
  endtask

  task automatic test_back_to_back();
    instr_t ins0[4];
    instr_t ins1[4];
    int     order[$];
    int     when[$];
    int     idx0;
    int     idx1;
    int     cyc;
    opcode_t ops[4];
    ops = '{add, mul, sub, div};
    for (int k = 0; k < 4; k++) begin
      ins0[k] = mk(ops[k], sign, $urandom, $urandom_range(1, 1000));
      ins1[k] = mk(ops[3 - k], unsign, $urandom, $urandom_range(1, 1000));
    end
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    idx0 = 0;
    idx1 = 0;
    cyc = 0;
    while ((idx0 < 4 || idx1 < 4) && cyc < 200) begin
      if (idx0 < 4) set_req(1'b0, 1'b1, ins0[idx0]); else bus.req0_valid = 1'b0;
      if (idx1 < 4) set_req(1'b1, 1'b1, ins1[idx1]); else bus.req1_valid = 1'b0;
      @(negedge clk);
      if (bus.req0_ready) begin order.push_back(0); when.push_back(cyc); idx0++; end
      if (bus.req1_ready) begin order.push_back(1); when.push_back(cyc); idx1++; end
      tick();
      cyc++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    checks++;
    if (order.size() != 8) begin
      failures++;
      $display("FAIL b2b_count got %0d grants expected 8", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      checks++;
      if (order[k] != (k % 2)) begin
        failures++;
        $display("FAIL b2b_order grant %0d got id %0d expected %0d", k, order[k], k % 2);
      end
      if (k > 0) begin
        checks++;
        if (when[k] - when[k-1] != 3) begin
          failures++;
          $display("FAIL b2b_spacing grant %0d got spacing %0d expected 3", k, when[k] - when[k-1]);
        end
      end
    end
    wait_drain("b2b");
  endtask

  task automatic test_div();
    run_one(1'b1, mk(div, unsign, 32'd100, 32'd0), DZ, 1'b1, "div_u_zero");
    run_one(1'b0, mk(div, sign, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000, 1'b0, "div_s_ovf");
    run_one(1'b0, mk(div, sign, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD, 1'b0, "div_s_trunc");
    run_one(1'b0, mk(div, sign, 32'd7, 32'd0), DZ, 1'b1, "div_s_zero");
  endtask

  task automatic test_stall();
    logic [31:0] d;
    logic        id;
    logic        dz;
    int          n;
    tick();
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, mk(mul, sign, 32'hFFFF_FFFD, 32'd7));
    n = 0;
    @(negedge clk);
    while (!bus.req0_ready && n < 20) begin @(negedge clk); n++; end
    tick();
    set_req(1'b0, 1'b1, mk(sub, unsign, 32'd10, 32'd3));
    bus.req1_valid = 1'b1;
    bus.req1_instr = mk(add, unsign, 32'd1, 32'd1);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
    d = bus.rsp_data.u_data;
    id = bus.rsp_id;
    dz = bus.rsp_dz;
    checks++;
    if ({bus.rsp_valid, d, id, dz} !== {1'b1, 32'hFFFF_FFEB, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL stall_rsp got valid=%b data=%h id=%b dz=%b expected 1/ffffffeb/0/0",
               bus.rsp_valid, d, id, dz);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_data.u_data, bus.rsp_id, bus.rsp_dz, bus.busy,
           bus.req0_ready, bus.req1_ready} !== {1'b1, d, id, dz, 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold cycle %0d got valid=%b data=%h busy=%b r0=%b r1=%b expected 1/%h/1/0/0",
                 k, bus.rsp_valid, bus.rsp_data.u_data, bus.busy, bus.req0_ready, bus.req1_ready, d);
      end
    end
    bus.req1_valid = 1'b0;
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_handshake_cycle got req0_ready=%b expected 0", bus.req0_ready);
    end
    tick();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.req0_ready, bus.rsp_valid, bus.busy} !== 3'b100) begin
      failures++;
      $display("FAIL stall_next_accept got r0=%b rsp_valid=%b busy=%b expected 1/0/0",
               bus.req0_ready, bus.rsp_valid, bus.busy);
    end
    tick();
    bus.req0_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_shifts();
    instr_t i;
    run_one(1'b0, mk(sr, sign, 32'h8000_0010, 32'h0), 32'hC000_0008, 1'b0, "sr_s");
    run_one(1'b1, mk(sr, unsign, 32'h8000_0010, 32'h0), 32'h2000_0004, 1'b0, "sr_u");
    run_one(1'b0, mk(sl, unsign, 32'd1, 32'h0), 32'd4, 1'b0, "sl_u");
    run_one(1'b1, mk(sl, sign, 32'h4000_0001, 32'h0), 32'h8000_0002, 1'b0, "sl_s");
    i = mk(add, sign, 32'd9, 32'd9);
    i.opc = opcode_t'(3'd7);
    run_one(1'b0, i, 32'h0, 1'b0, "bad_opc");
    i = mk(div, sign, 32'd9, 32'd0);
    i.op_type = operand_type_t'(2'd3);
    run_one(1'b1, i, 32'h0, 1'b0, "bad_type");
  endtask

  task automatic test_reset_mid();
    int   n;
    logic got;
    tick();
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, mk(add, unsign, 32'd1, 32'd2));
    n = 0;
    @(negedge clk);
    while (!bus.req0_ready && n < 20) begin @(negedge clk); n++; end
    tick();
    bus.req0_valid = 1'b0;
    set_req(1'b1, 1'b1, mk(sub, sign, 32'd50, 32'd8));
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    set_req(1'b0, 1'b1, mk(mul, unsign, 32'd6, 32'd7));
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.busy, bus.req0_ready, bus.req1_ready} !== 4'b0010) begin
      failures++;
      $display("FAIL rst_mid_after got rsp_valid=%b busy=%b r0=%b r1=%b expected 0/0/1/0",
               bus.rsp_valid, bus.busy, bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = bus.req1_ready;
      tick();
      n++;
    end
    bus.req1_valid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rst_mid_req1 got req1_ready=0 expected 1");
    end
    wait_drain("rst_mid");
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_instr = '0;
    bus.req1_instr = '0;
    bus.rsp_ready  = 1'b1;
    test_reset();
    test_add();
    test_back_to_back();
    test_div();
    test_stall();
    test_shifts();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_sb got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
